// File: rtl/mem_arbiter.sv
// Two-port (icache/dcache) burst arbiter in front of a single beat-level memory port.
// Optional round-robin arbitration is enabled by defining MEM_ARBITER_RR_EN.
module mem_arbiter #(
    parameter int BURST_LEN = 4,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_rvalid,
    output logic [31:0]       ic_rdata,
    output logic              ic_done,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [31:0]       dc_wdata,
    output logic              dc_wready,
    output logic              dc_rvalid,
    output logic [31:0]       dc_rdata,
    output logic              dc_done,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              err
);

    localparam int CW = $clog2(BURST_LEN) + 1;
    localparam logic [CW-1:0]     LAST  = CW'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] BEATM = ADDR_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] BMASK = ADDR_W'(BURST_LEN * 4 - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state_q;
    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] base_q;
    logic [CW-1:0]     issue_q;
    logic [CW-1:0]     ret_q;
    logic              valid_q;
    logic              ic_done_q;
    logic              dc_done_q;
    logic              err_q;
`ifdef MEM_ARBITER_RR_EN
    logic              last_q;
`endif

    logic              accept;
    logic              busy;
    logic              rd_fwd;
    logic              ret_last;
    logic              go_done;
    logic              gnt_dc;
    logic [ADDR_W-1:0] beat_off;

    assign accept   = valid_q && mem_ready;
    assign busy     = (state_q == ISSUE) || (state_q == WAIT);
    assign rd_fwd   = busy && !we_q && mem_rvalid;
    assign ret_last = rd_fwd && (ret_q == LAST);
    assign go_done  = ((state_q == ISSUE) &&
                       (ret_last || (accept && (issue_q == LAST) && we_q))) ||
                      ((state_q == WAIT) && ret_last);

    // owner_q = 1 means the dcache holds the grant
`ifdef MEM_ARBITER_RR_EN
    assign gnt_dc = dc_req && !(ic_req && last_q);
`else
    assign gnt_dc = dc_req;
`endif

    // wrap the beat offset inside the aligned burst window
    assign beat_off = (ADDR_W'(issue_q) & BEATM) << 2;
    assign mem_addr = (base_q & ~BMASK) | ((base_q + beat_off) & BMASK);

    assign mem_valid = valid_q;
    assign mem_we    = valid_q && we_q;
    assign mem_wdata = dc_wdata;
    assign dc_wready = accept && we_q;
    assign ic_rvalid = rd_fwd && !owner_q;
    assign dc_rvalid = rd_fwd && owner_q;
    assign ic_rdata  = ic_rvalid ? mem_rdata : 32'h0;
    assign dc_rdata  = dc_rvalid ? mem_rdata : 32'h0;
    assign ic_done   = ic_done_q;
    assign dc_done   = dc_done_q;
    assign err       = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            base_q    <= '0;
            issue_q   <= '0;
            ret_q     <= '0;
            valid_q   <= 1'b0;
            ic_done_q <= 1'b0;
            dc_done_q <= 1'b0;
            err_q     <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
            last_q    <= 1'b0;
`endif
        end else begin
            ic_done_q <= 1'b0;
            dc_done_q <= 1'b0;
            if (mem_rvalid && ((state_q == IDLE) || (state_q == DONE)))
                err_q <= 1'b1;
            if (rd_fwd)
                ret_q <= ret_q + CW'(1);
            if (accept)
                issue_q <= issue_q + CW'(1);
            if (go_done) begin
                ic_done_q <= !owner_q;
                dc_done_q <= owner_q;
            end
            unique case (state_q)
                IDLE: begin
                    if (ic_req || dc_req) begin
                        owner_q <= gnt_dc;
                        we_q    <= gnt_dc && dc_we;
                        base_q  <= gnt_dc ? dc_addr : ic_addr;
                        issue_q <= '0;
                        ret_q   <= '0;
                        valid_q <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (go_done) begin
                        valid_q <= 1'b0;
                        state_q <= DONE;
                    end else if (accept && (issue_q == LAST)) begin
                        valid_q <= 1'b0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (go_done)
                        state_q <= DONE;
                end
                DONE: begin
`ifdef MEM_ARBITER_RR_EN
                    last_q  <= owner_q;
`endif
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: refill, write burst, arbitration,
// reset mid-read with late returns, and zero-latency read completion.
module tb_mem_arbiter;

    localparam logic [31:0] K = 32'hCAFE_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ic_req, dc_req, dc_we;
    logic [31:0] ic_addr, dc_addr, dc_wdata;
    logic        ic_rvalid, ic_done, dc_wready, dc_rvalid, dc_done;
    logic [31:0] ic_rdata, dc_rdata;
    logic        mem_valid, mem_we, mem_ready, mem_rvalid, err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [1:0]  mode;
    logic        rdy_lvl, tog, man_rv;
    logic        tog_q = 1'b1;
    logic        p0 = 1'b0, p1 = 1'b0;
    logic [31:0] a0 = '0, a1 = '0;
    logic        zl;
    logic [31:0] wtab [4];
    int          wd_idx = 0, wd_snap = 0;
    int          cyc = 0, total = 0, bad = 0;

    int          acc_n = 0, ic_rv_n = 0, dc_rv_n = 0;
    int          ic_dn_n = 0, dc_dn_n = 0, wr_n = 0, dc_any = 0;
    int          dc_dn_cyc = 0;
    logic [31:0] acc_addr [64];
    logic [31:0] acc_data [64];
    int          acc_cyc  [64];
    logic [31:0] ic_rd    [64];
    logic [31:0] last_dc_rd = '0;

    mem_arbiter #(.BURST_LEN(4), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr),
        .ic_rvalid(ic_rvalid), .ic_rdata(ic_rdata), .ic_done(ic_done),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr),
        .dc_wdata(dc_wdata), .dc_wready(dc_wready),
        .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata), .dc_done(dc_done),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err(err)
    );

    always #5 clk = ~clk;

    assign mem_ready  = tog ? tog_q : rdy_lvl;
    assign zl         = mem_valid && mem_ready && !mem_we;
    assign mem_rvalid = (mode == 2'd0) ? p1 : (mode == 2'd1) ? zl : man_rv;
    assign mem_rdata  = (mode == 2'd0) ? (a1 ^ K) :
                        (mode == 2'd1) ? (mem_addr ^ K) : 32'h1234_5678;
    assign dc_wdata   = wtab[2'(wd_idx - wd_snap)];

    // memory model: two-cycle read latency, optional 1,0,1 ready pattern
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        tog_q <= tog ? ~tog_q : 1'b1;
        p0    <= mem_valid && mem_ready && !mem_we;
        a0    <= mem_addr;
        p1    <= p0;
        a1    <= a0;
        if (dc_wready)
            wd_idx <= wd_idx + 1;
    end

    always @(negedge clk) begin
        if (rst) begin
            if (ic_rvalid) begin
                if (ic_rv_n < 64) ic_rd[ic_rv_n] = ic_rdata;
                ic_rv_n++;
            end
            if (dc_rvalid) begin
                last_dc_rd = dc_rdata;
                dc_rv_n++;
            end
            if (ic_done) ic_dn_n++;
            if (dc_done) begin
                dc_dn_n++;
                dc_dn_cyc = cyc;
            end
            if (dc_wready) wr_n++;
            if (dc_rvalid || dc_done || dc_wready || (dc_rdata != 0))
                dc_any++;
            if (mem_valid && mem_ready) begin
                if (acc_n < 64) begin
                    acc_addr[acc_n] = mem_addr;
                    acc_data[acc_n] = mem_wdata;
                    acc_cyc[acc_n]  = cyc;
                end
                acc_n++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_dn(input int target);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            if (ic_dn_n + dc_dn_n >= target) return;
        end
        chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    int s_acc, s_icrv, s_icdn, s_dcdn, s_dcrv, s_wr, s_any;

    initial begin
        wtab[0] = 32'hA0A0_0001; wtab[1] = 32'hB0B0_0002;
        wtab[2] = 32'hC0C0_0003; wtab[3] = 32'hD0D0_0004;
        ic_req = 0; dc_req = 0; dc_we = 0;
        ic_addr = '0; dc_addr = '0;
        mode = 2'd0; rdy_lvl = 1; tog = 0; man_rv = 0;

        idle(3);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_wready", 32'(dc_wready), 32'd0);
        chk("rst_ic_done", 32'(ic_done), 32'd0);
        chk("rst_dc_done", 32'(dc_done), 32'd0);
        chk("rst_ic_rvalid", 32'(ic_rvalid), 32'd0);
        @(posedge clk); #1 rst = 1;
        idle(1);

        // icache refill, two-cycle memory latency
        s_acc = acc_n; s_icrv = ic_rv_n; s_icdn = ic_dn_n; s_any = dc_any;
        ic_addr = 32'h100; ic_req = 1;
        wait_dn(ic_dn_n + dc_dn_n + 1);
        ic_req = 0;
        idle(3);
        chk("ic_beats", 32'(acc_n - s_acc), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("ic_addr", acc_addr[s_acc + i], 32'h100 + 32'(4 * i));
        chk("ic_rvalid_cnt", 32'(ic_rv_n - s_icrv), 32'd4);
        chk("ic_rdata0", ic_rd[s_icrv], 32'h100 ^ K);
        chk("ic_rdata3", ic_rd[s_icrv + 3], 32'h10C ^ K);
        chk("ic_done_cnt", 32'(ic_dn_n - s_icdn), 32'd1);
        chk("dc_quiet", 32'(dc_any - s_any), 32'd0);
        chk("ic_err", 32'(err), 32'd0);

        // simultaneous requests, both held across two grants
        s_acc = acc_n; s_icdn = ic_dn_n; s_dcdn = dc_dn_n;
        ic_addr = 32'h300; dc_addr = 32'h400; dc_we = 0;
        ic_req = 1; dc_req = 1;
        wait_dn(ic_dn_n + dc_dn_n + 2);
        ic_req = 0; dc_req = 0;
        idle(3);
        chk("arb_first", acc_addr[s_acc], 32'h400);
`ifdef MEM_ARBITER_RR_EN
        chk("arb_second", acc_addr[s_acc + 4], 32'h300);
        chk("arb_dc_done", 32'(dc_dn_n - s_dcdn), 32'd1);
        chk("arb_ic_done", 32'(ic_dn_n - s_icdn), 32'd1);
`else
        chk("arb_second", acc_addr[s_acc + 4], 32'h400);
        chk("arb_dc_done", 32'(dc_dn_n - s_dcdn), 32'd2);
        chk("arb_ic_done", 32'(ic_dn_n - s_icdn), 32'd0);
`endif

        // dcache write burst with mem_ready toggling
        s_acc = acc_n; s_wr = wr_n; s_dcdn = dc_dn_n;
        wd_snap = wd_idx;
        tog = 1; dc_addr = 32'h200; dc_we = 1; dc_req = 1;
        wait_dn(ic_dn_n + dc_dn_n + 1);
        dc_req = 0; dc_we = 0; tog = 0;
        idle(3);
        chk("wr_beats", 32'(acc_n - s_acc), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("wr_addr", acc_addr[s_acc + i], 32'h200 + 32'(4 * i));
            chk("wr_data", acc_data[s_acc + i], wtab[i]);
        end
        chk("wr_wready_cnt", 32'(wr_n - s_wr), 32'd4);
        chk("wr_done_cnt", 32'(dc_dn_n - s_dcdn), 32'd1);
        chk("wr_done_cycle", 32'(dc_dn_cyc), 32'(acc_cyc[s_acc + 3] + 1));
        chk("wr_err", 32'(err), 32'd0);

        // reset in WAIT after two returns, then two late returns
        mode = 2'd2;
        s_acc = acc_n; s_icrv = ic_rv_n; s_icdn = ic_dn_n;
        ic_addr = 32'h500; ic_req = 1;
        for (int i = 0; i < 30; i++) begin
            if (acc_n - s_acc >= 4) break;
            idle(1);
        end
        chk("rw_issued", 32'(acc_n - s_acc), 32'd4);
        man_rv = 1;
        idle(2);
        man_rv = 0;
        rst = 0; ic_req = 0;
        idle(1);
        chk("rw_in_reset_err", 32'(err), 32'd0);
        chk("rw_in_reset_valid", 32'(mem_valid), 32'd0);
        @(posedge clk); #1 rst = 1;
        man_rv = 1;
        @(posedge clk); #1;
        @(posedge clk); #1 man_rv = 0;
        idle(2);
        chk("rw_no_done", 32'(ic_dn_n - s_icdn), 32'd0);
        chk("rw_rvalid_cnt", 32'(ic_rv_n - s_icrv), 32'd2);
        chk("rw_err", 32'(err), 32'd1);
        chk("rw_idle", 32'(mem_valid), 32'd0);

        mode = 2'd0;
        s_acc = acc_n; s_icdn = ic_dn_n;
        ic_addr = 32'h600; ic_req = 1;
        wait_dn(ic_dn_n + dc_dn_n + 1);
        ic_req = 0;
        idle(3);
        chk("rw_next_addr", acc_addr[s_acc], 32'h600);
        chk("rw_next_done", 32'(ic_dn_n - s_icdn), 32'd1);
        chk("rw_err_sticky", 32'(err), 32'd1);

        // zero-latency memory: last return coincides with last issue
        mode = 2'd1;
        s_acc = acc_n; s_dcrv = dc_rv_n; s_dcdn = dc_dn_n;
        dc_addr = 32'h700; dc_we = 0; dc_req = 1;
        wait_dn(ic_dn_n + dc_dn_n + 1);
        dc_req = 0;
        idle(3);
        chk("zl_beats", 32'(acc_n - s_acc), 32'd4);
        chk("zl_rvalid_cnt", 32'(dc_rv_n - s_dcrv), 32'd4);
        chk("zl_done_cnt", 32'(dc_dn_n - s_dcdn), 32'd1);
        chk("zl_done_cycle", 32'(dc_dn_cyc), 32'(acc_cyc[s_acc + 3] + 1));
        chk("zl_rdata", last_dc_rd, 32'h70C ^ K);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
